// File: rtl/dbf_apod_stage.sv
// dbf_apod_stage
// Per-channel apodization stage of the digital beamformer. The stage takes
// coarse-delayed samples for one receive line and multiplies each sample by
// the channel weight that was latched when the line started. The output is
// the full-precision signed product.
//
// A line begins on a rising edge of start, provided tx_en is low. The line
// ends after line_len samples have been accepted. tx_en aborts a line that
// is in progress.
//
// Ports
//   clk                clock; all state changes on its rising edge
//   rst_n              asynchronous active-low reset
//   tx_en              transmit active; aborts or blocks reception
//   start              receive-line request (rising edge only)
//   cd_din/_valid      signed coarse-delayed sample and its qualifier
//   apo_din            signed apodization weight, latched at line start
//   line_len           samples per line, latched at line start (0 acts as 1)
//   dbf_ch_dout/_valid signed weighted sample, zero when not valid
//   line_done          pulses with the output of the last sample of a line
//   busy               high whenever the FSM is not IDLE
//
// state  | meaning
// IDLE   | waiting for a start rising edge with tx_en low
// ACTIVE | accepting valid samples until line_len have been taken
// DRAIN  | two cycles that let the last sample leave the pipeline
//
// OUT_WD must be at least INPUT_WD + APO_WD so the product is never truncated.
module dbf_apod_stage #(
  parameter int INPUT_WD = 14,
  parameter int APO_WD   = 16,
  parameter int OUT_WD   = 32,
  parameter int LEN_WD   = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_en,
  input  logic                start,
  input  logic [INPUT_WD-1:0] cd_din,
  input  logic                cd_din_valid,
  input  logic [APO_WD-1:0]   apo_din,
  input  logic [LEN_WD-1:0]   line_len,
  output logic [OUT_WD-1:0]   dbf_ch_dout,
  output logic                dbf_ch_dout_valid,
  output logic                line_done,
  output logic                busy
);

  localparam int PROD_WD = INPUT_WD + APO_WD;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                start_q;
  logic                armed_q, armed_d;
  logic                start_rise;
  logic [APO_WD-1:0]   apo_q, apo_d;
  logic [LEN_WD-1:0]   len_q, len_d;
  logic [LEN_WD-1:0]   cnt_q, cnt_d;
  logic                drain_q, drain_d;
  logic                accept, last, abort;

  logic [INPUT_WD-1:0] s1_data_q, s1_data_d;
  logic                s1_valid_q, s1_valid_d;
  logic                s1_last_q, s1_last_d;

  logic signed [PROD_WD-1:0] prod;
  logic [OUT_WD-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                done_q, done_d;

  // armed_q stays low after reset until start has been sampled low. This
  // keeps a start level that is held through reset release from being
  // taken as an edge.
  assign start_rise = start & ~start_q & armed_q;
  assign armed_d    = armed_q | ~start;

  assign abort  = tx_en & (state_q != IDLE);
  assign accept = (state_q == ACTIVE) & cd_din_valid & ~tx_en;
  assign last   = (cnt_q == len_q - LEN_WD'(1));

  always_comb begin
    state_d = state_q;
    apo_d   = apo_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start_rise && !tx_en) begin
          state_d = ACTIVE;
          apo_d   = apo_din;
          len_d   = (line_len == '0) ? LEN_WD'(1) : line_len;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (tx_en) begin
          state_d = IDLE;
        end else if (cd_din_valid) begin
          cnt_d = cnt_q + LEN_WD'(1);
          if (last) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (tx_en || drain_q) begin
          state_d = IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new line can only be latched from IDLE, and by then stage 1 is empty.
  // So apo_q is stable for every sample that is still in flight.
  assign prod = $signed(s1_data_q) * $signed(apo_q);

  always_comb begin
    s1_valid_d   = accept;
    s1_data_d    = accept ? cd_din : '0;
    s1_last_d    = accept & last;
    dout_valid_d = s1_valid_q & ~abort;
    dout_d       = dout_valid_d ? OUT_WD'(prod) : '0;
    done_d       = dout_valid_d & s1_last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      armed_q      <= 1'b0;
      apo_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      s1_data_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      armed_q      <= armed_d;
      apo_q        <= apo_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      s1_data_q    <= s1_data_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
    end
  end

  assign dbf_ch_dout       = dout_q;
  assign dbf_ch_dout_valid = dout_valid_q;
  assign line_done         = done_q;
  assign busy              = (state_q != IDLE);

endmodule
